// File: rtl/ex1_1_result_fifo.sv
// Result FIFO behind the ex1_1 multiply-add datapath: circular buffer with a
// valid/ready drain port and a sticky overflow flag. Optional feature macro:
// RESULT_FIFO_PEAK_EN (tracks the largest accepted word on peak).
module ex1_1_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CNTW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             valido,
  input  logic [WIDTH-1:0] data_out,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             overflow,
  output logic [WIDTH-1:0] peak
);

  localparam int PTRW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wr_en;
  logic             rd_fire;

  assign full     = (count_q == CNTW'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;

  // Storage is read directly; an empty FIFO presents zero, never the input.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  assign rd_fire  = rd_valid && rd_ready;
  assign wr_en    = valido && (!full || rd_fire);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
    end

    case ({wr_en, rd_fire})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    if (valido && !wr_en) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // When full with a concurrent read, wr_ptr equals rd_ptr: the head word is
  // consumed this edge and its slot is overwritten on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_out;
    end
  end

`ifdef RESULT_FIFO_PEAK_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (wr_en && (data_out > peak_q)) begin
      peak_d = data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_ex1_1_result_fifo.sv
// Directed bench for ex1_1_result_fifo: reset, fill/drain, overflow, full
// read+write, pointer wrap and peak tracking with hand-computed expectations.
module tb_ex1_1_result_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_;
  logic          valido;
  logic [W-1:0]  data_out;
  logic          rd_ready;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic [W-1:0]  peak;

  int errs = 0;
  int nchk = 0;

  ex1_1_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .valido   (valido),
    .data_out (data_out),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .peak     (peak)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    nchk++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Expected peak: tracks the value when the feature is built in, else zero.
  function automatic logic [31:0] pk(input logic [31:0] v);
`ifdef RESULT_FIFO_PEAK_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    valido   = 1'b1;
    data_out = d;
    step();
    valido   = 1'b0;
  endtask

  task automatic drain_chk(input string tag, input logic [31:0] expv);
    rd_ready = 1'b1;
    chk(tag, rd_data, expv);
    chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst_     = 1'b0;
    valido   = 1'b0;
    data_out = '0;
    rd_ready = 1'b0;
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rdvalid", 32'(rd_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_peak", peak, 32'd0);
    chk("rst_rddata", rd_data, 32'd0);
    rst_ = 1'b1;
    step();

    // rd_ready while empty must not underflow
    rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    chk("empty_rd_count", 32'(count), 32'd0);
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);

    // no combinational pass-through; visible one edge later
    valido   = 1'b1;
    data_out = 32'd77;
    #1;
    chk("nopass_valid", 32'(rd_valid), 32'd0);
    chk("nopass_data", rd_data, 32'd0);
    @(posedge clk);
    #1;
    valido = 1'b0;
    chk("lat_count", 32'(count), 32'd1);
    drain_chk("lat_data", 32'd77);
    chk("lat_empty", 32'(count), 32'd0);
    chk("lat_peak", peak, pk(32'd77));

    // fill / drain
    for (int i = 1; i <= 8; i++) push(32'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) drain_chk($sformatf("drain%0d", i), 32'(i));
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_full", 32'(full), 32'd0);
    chk("drain_valid", 32'(rd_valid), 32'd0);
    chk("drain_ovf", 32'(overflow), 32'd0);
    chk("drain_peak", peak, pk(32'd77));

    // overflow: word 99 dropped
    for (int i = 1; i <= 8; i++) push(32'(i));
    push(32'd99);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_peak", peak, pk(32'd77));
    for (int i = 1; i <= 8; i++) drain_chk($sformatf("ovf_drain%0d", i), 32'(i));
    chk("ovf_empty", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // asynchronous reset mid-traffic with five words stored
    for (int i = 20; i <= 24; i++) push(32'(i));
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_peak", peak, pk(32'd77));
    valido   = 1'b1;
    data_out = 32'd55;
    rd_ready = 1'b1;
    #2;
    rst_ = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_peak", peak, 32'd0);
    chk("arst_data", rd_data, 32'd0);
    valido   = 1'b0;
    rd_ready = 1'b0;
    step();
    rst_ = 1'b1;
    step();
    chk("post_rst_count", 32'(count), 32'd0);

    // full with simultaneous read and write
    for (int i = 10; i <= 17; i++) push(32'(i));
    valido   = 1'b1;
    data_out = 32'd42;
    rd_ready = 1'b1;
    step();
    valido   = 1'b0;
    rd_ready = 1'b0;
    chk("frw_count", 32'(count), 32'd8);
    chk("frw_full", 32'(full), 32'd1);
    chk("frw_ovf", 32'(overflow), 32'd0);
    for (int i = 11; i <= 17; i++) drain_chk($sformatf("frw_drain%0d", i), 32'(i));
    drain_chk("frw_last42", 32'd42);
    chk("frw_empty", 32'(count), 32'd0);
    chk("frw_peak", peak, pk(32'd42));

    // continuous streaming wraps pointers twice with count staying at 1
    for (int k = 0; k < 20; k++) begin
      valido   = 1'b1;
      data_out = 32'(200 + k);
      rd_ready = 1'b1;
      step();
      chk($sformatf("wrap_data%0d", k), rd_data, 32'(200 + k));
      chk($sformatf("wrap_cnt%0d", k), 32'(count), 32'd1);
    end
    valido = 1'b0;
    step();
    rd_ready = 1'b0;
    chk("wrap_empty", 32'(count), 32'd0);
    chk("wrap_ovf", 32'(overflow), 32'd0);
    chk("wrap_peak", peak, pk(32'd219));

    // peak tracking and dropped-word exclusion
    rst_ = 1'b0;
    step();
    rst_ = 1'b1;
    step();
    push(32'd5);
    push(32'd300);
    push(32'd17);
    chk("peak_300", peak, pk(32'd300));
    for (int i = 1; i <= 5; i++) push(32'(i));
    chk("peak_full", 32'(full), 32'd1);
    push(32'd1000);
    chk("peak_drop_ovf", 32'(overflow), 32'd1);
    chk("peak_drop", peak, pk(32'd300));
    chk("peak_drop_cnt", 32'(count), 32'd8);
    drain_chk("pk_d0", 32'd5);
    drain_chk("pk_d1", 32'd300);
    drain_chk("pk_d2", 32'd17);
    for (int i = 1; i <= 5; i++) drain_chk($sformatf("pk_d%0d", i + 2), 32'(i));
    chk("pk_empty", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
